// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB4 master port between NUM_REQ local
// requesters, sequencing SETUP/ACCESS with PREADY wait states and a timeout.
module apb_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTRB,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY,
  input  logic                             PSLVERR,
  output logic [1:0]                       dbg_state
);

  // Handshake: a command is taken when req_valid[i] and req_ready[i] are both
  // high in the same cycle; req_ready is a one-cycle pulse driven only in IDLE.
  // rsp_valid[i] is a one-cycle pulse with no back-pressure.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  state_t                  state, next_state;
  logic [PW-1:0]           ptr, g_q, gnt_idx, cand;
  logic                    found, grant, acc_done, acc_tmo, wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic [TW-1:0]           timer;

  logic [ADDR_WIDTH-1:0]   addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_a [NUM_REQ];
  logic [STRB_WIDTH-1:0]   strb_a  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign strb_a[i]  = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
  end

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant    = (state == S_IDLE) && found;
  assign acc_done = (state == S_ACCESS) && PREADY;
  assign acc_tmo  = (state == S_ACCESS) && !PREADY && (TIMEOUT != 0) && (timer == TMO_LAST);

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    case (state)
      S_IDLE: begin
        if (found) begin
          next_state = S_SETUP;
          if (!PRESET) req_ready[gnt_idx] = 1'b1;
        end
      end
      S_SETUP:  next_state = S_ACCESS;
      S_ACCESS: if (acc_done || acc_tmo) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ptr       <= '0;
      g_q       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      timer     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (grant) begin
        g_q     <= gnt_idx;
        ptr     <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        wr_q    <= req_write[gnt_idx];
        addr_q  <= addr_a[gnt_idx];
        // Reads carry zero data and strobes on the bus.
        wdata_q <= req_write[gnt_idx] ? wdata_a[gnt_idx] : '0;
        strb_q  <= req_write[gnt_idx] ? strb_a[gnt_idx] : '0;
      end
      if (state == S_SETUP)                timer <= '0;
      else if (state == S_ACCESS && !PREADY) timer <= timer + 1'b1;
      if (acc_done) begin
        rsp_valid[g_q] <= 1'b1;
        rsp_rdata      <= wr_q ? '0 : PRDATA;
        rsp_err        <= PSLVERR;
      end else if (acc_tmo) begin
        rsp_valid[g_q] <= 1'b1;
        rsp_err        <= 1'b1;
      end
    end
  end

  assign PSEL      = (state == S_SETUP) || (state == S_ACCESS);
  assign PENABLE   = (state == S_ACCESS);
  assign PWRITE    = PSEL ? wr_q    : 1'b0;
  assign PADDR     = PSEL ? addr_q  : '0;
  assign PWDATA    = PSEL ? wdata_q : '0;
  assign PSTRB     = PSEL ? strb_q  : '0;
  assign dbg_state = state;

endmodule
